// File: rtl/alu_muldiv_if.sv
// Flag record plus the start/busy/done operand/result bundle between the sequencer and alu_muldiv.
package alu_muldiv_pkg;
    typedef struct packed {
        logic s;
        logic z;
        logic ac;
        logic p;
        logic cy;
        logic v;
    } flags_t;
endpackage

interface alu_muldiv_if #(
    parameter int DATA_W = 16
);
    import alu_muldiv_pkg::*;

    logic              start;
    logic [1:0]        operation;
    logic              wide;
    logic [DATA_W-1:0] ta;
    logic [DATA_W-1:0] ta_hi;
    logic [DATA_W-1:0] tb;
    flags_t            flags_in;
    logic [DATA_W-1:0] result_lo;
    logic [DATA_W-1:0] result_hi;
    flags_t            flags;
    logic              busy;
    logic              done;
    logic              div_error;

    modport master (
        output start, operation, wide, ta, ta_hi, tb, flags_in,
        input  result_lo, result_hi, flags, busy, done, div_error
    );

    modport slave (
        input  start, operation, wide, ta, ta_hi, tb, flags_in,
        output result_lo, result_hi, flags, busy, done, div_error
    );
endinterface

// File: rtl/alu_muldiv.sv
// Radix-2 sequential MULU/MUL/DIVU/DIV: done in cycle n+3 (cycle 2 on divide pre-check error); start ignored while busy.
// ALU_MULDIV_FAST_MUL_EN swaps the iterative multiply for a single-cycle multiplier (done in cycle 2).
module alu_muldiv #(
    parameter int DATA_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);
    import alu_muldiv_pkg::*;

    localparam int W     = DATA_W;
    localparam int H     = DATA_W / 2;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [W-1:0]     ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0]   ONE_2W = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] LAST_H = CNT_W'(H - 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_FIX, S_DONE} state_t;

    function automatic logic [W-1:0] mask_n(input logic wide);
        return wide ? {W{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
    endfunction

    function automatic logic sign_n(input logic wide, input logic [W-1:0] x);
        return wide ? x[W-1] : x[H-1];
    endfunction

    function automatic logic [W-1:0] neg_n(input logic wide, input logic [W-1:0] x);
        return (~x + ONE_W) & mask_n(wide);
    endfunction

    function automatic logic [2*W-1:0] neg_2n(input logic wide, input logic [2*W-1:0] x);
        return (~x + ONE_2W) & (wide ? {(2*W){1'b1}} : {{W{1'b0}}, {W{1'b1}}});
    endfunction

    function automatic logic [2*W-1:0] join_2n(input logic wide, input logic [W-1:0] hi,
                                               input logic [W-1:0] lo);
        return wide ? {hi, lo} : {{W{1'b0}}, hi[H-1:0], lo[H-1:0]};
    endfunction

    function automatic logic [W-1:0] lo_of(input logic wide, input logic [2*W-1:0] x);
        return wide ? x[W-1:0] : {{H{1'b0}}, x[H-1:0]};
    endfunction

    function automatic logic [W-1:0] hi_of(input logic wide, input logic [2*W-1:0] x);
        return wide ? x[2*W-1:W] : {{H{1'b0}}, x[W-1:H]};
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic             r_wide;
    flags_t           r_flags_in;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_a_hi;
    logic [W-1:0]     r_b;
    logic [2*W-1:0]   r_prod;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_ovf_pend;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_res_lo;
    logic [W-1:0]     r_res_hi;
    flags_t           r_flags;
    logic             r_div_error;

    // Operand magnitudes and divide pre-checks, evaluated in CHECK
    logic           w_is_div, w_is_sgn;
    logic           w_sa, w_sb, w_sdvd;
    logic [W-1:0]   w_mag_a, w_mag_b, w_mag_dvd_lo, w_mag_dvd_hi;
    logic [2*W-1:0] w_dvd, w_mag_dvd;
    logic           w_hi_ge, w_chk_err;

    assign w_is_div     = r_op[1];
    assign w_is_sgn     = r_op[0];
    assign w_sa         = w_is_sgn & sign_n(r_wide, r_a);
    assign w_sb         = w_is_sgn & sign_n(r_wide, r_b);
    assign w_sdvd       = w_is_sgn & sign_n(r_wide, r_a_hi);
    assign w_mag_a      = w_sa ? neg_n(r_wide, r_a) : r_a;
    assign w_mag_b      = w_sb ? neg_n(r_wide, r_b) : r_b;
    assign w_dvd        = join_2n(r_wide, r_a_hi, r_a);
    assign w_mag_dvd    = w_sdvd ? neg_2n(r_wide, w_dvd) : w_dvd;
    assign w_mag_dvd_lo = lo_of(r_wide, w_mag_dvd);
    assign w_mag_dvd_hi = hi_of(r_wide, w_mag_dvd);
    // A high half >= divisor means the quotient needs more than n bits.
    assign w_hi_ge      = w_mag_dvd_hi >= w_mag_b;
    assign w_chk_err    = w_is_div & ((r_b == '0) | (~w_is_sgn & w_hi_ge));

    // One iteration: multiply shifts-and-adds, divide shifts-and-subtracts (restoring)
    logic         w_q_msb, w_sub_ok, w_last;
    logic [W:0]   w_shift;
    logic [W-1:0] w_diff;

    assign w_q_msb  = r_wide ? r_q[W-1] : r_q[H-1];
    assign w_shift  = {r_rem, w_q_msb};
    assign w_sub_ok = w_shift >= {1'b0, r_div};
    assign w_diff   = w_shift[W-1:0] - r_div;
    assign w_last   = r_cnt == (r_wide ? LAST_W : LAST_H);

    logic           w_fast_mul;
    logic [2*W-1:0] w_prod_mag;
    logic           w_prod_neg;
`ifdef ALU_MULDIV_FAST_MUL_EN
    assign w_fast_mul = ~w_is_div;
    assign w_prod_mag = (r_state == S_CHECK) ? ({{W{1'b0}}, w_mag_a} * {{W{1'b0}}, w_mag_b})
                                             : r_prod;
    assign w_prod_neg = (r_state == S_CHECK) ? (w_sa ^ w_sb) : r_neg_q;
`else
    assign w_fast_mul = 1'b0;
    assign w_prod_mag = r_prod;
    assign w_prod_neg = r_neg_q;
`endif

    // Sign application and overflow detection
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_mul_lo, w_mul_hi, w_quo_mag, w_quo, w_rem, w_q_lim;
    logic           w_mul_ovf, w_div_ovf;
    flags_t         w_mul_flags;

    assign w_prod    = w_prod_neg ? neg_2n(r_wide, w_prod_mag) : w_prod_mag;
    assign w_mul_lo  = lo_of(r_wide, w_prod);
    assign w_mul_hi  = hi_of(r_wide, w_prod);
    assign w_mul_ovf = w_is_sgn ? (w_mul_hi != (sign_n(r_wide, w_mul_lo) ? mask_n(r_wide) : '0))
                                : (w_mul_hi != '0);
    assign w_quo_mag = r_q & mask_n(r_wide);
    assign w_quo     = r_neg_q ? neg_n(r_wide, w_quo_mag) : w_quo_mag;
    assign w_rem     = r_neg_r ? neg_n(r_wide, r_rem) : r_rem;
    assign w_q_lim   = r_wide ? (ONE_W << (W - 1)) : (ONE_W << (H - 1));
    assign w_div_ovf = w_is_sgn & (r_ovf_pend | (r_neg_q ? (w_quo_mag > w_q_lim)
                                                         : (w_quo_mag >= w_q_lim)));

    always_comb begin
        w_mul_flags    = r_flags_in;
        w_mul_flags.cy = w_mul_ovf;
        w_mul_flags.v  = w_mul_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = (w_chk_err || w_fast_mul) ? S_DONE : S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op        <= '0;
            r_wide      <= 1'b0;
            r_flags_in  <= '0;
            r_a         <= '0;
            r_a_hi      <= '0;
            r_b         <= '0;
            r_prod      <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_cnt       <= '0;
            r_res_lo    <= '0;
            r_res_hi    <= '0;
            r_flags     <= '0;
            r_div_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op       <= bus.operation;
                        r_wide     <= bus.wide;
                        r_flags_in <= bus.flags_in;
                        r_a        <= bus.ta & mask_n(bus.wide);
                        r_a_hi     <= bus.ta_hi & mask_n(bus.wide);
                        r_b        <= bus.tb & mask_n(bus.wide);
                    end
                end
                S_CHECK: begin
                    r_prod     <= '0;
                    r_cnt      <= '0;
                    r_rem      <= w_is_div ? w_mag_dvd_hi : '0;
                    r_q        <= w_is_div ? w_mag_dvd_lo : w_mag_b;
                    r_div      <= w_is_div ? w_mag_b : w_mag_a;
                    r_neg_q    <= w_is_div ? (w_sdvd ^ w_sb) : (w_sa ^ w_sb);
                    r_neg_r    <= w_sdvd;
                    r_ovf_pend <= w_hi_ge;
                    if (w_chk_err) begin
                        r_div_error <= 1'b1;
                    end else if (w_fast_mul) begin
                        r_res_lo    <= w_mul_lo;
                        r_res_hi    <= w_mul_hi;
                        r_flags     <= w_mul_flags;
                        r_div_error <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_prod <= {r_prod[2*W-2:0], 1'b0} + (w_q_msb ? {{W{1'b0}}, r_div} : '0);
                    r_q    <= {r_q[W-2:0], w_is_div & w_sub_ok};
                    r_rem  <= w_sub_ok ? w_diff : w_shift[W-1:0];
                end
                S_FIX: begin
                    if (w_is_div && w_div_ovf) begin
                        r_div_error <= 1'b1;
                    end else if (w_is_div) begin
                        r_res_lo    <= w_quo;
                        r_res_hi    <= w_rem;
                        r_flags     <= r_flags_in;
                        r_div_error <= 1'b0;
                    end else begin
                        r_res_lo    <= w_mul_lo;
                        r_res_hi    <= w_mul_hi;
                        r_flags     <= w_mul_flags;
                        r_div_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = r_state != S_IDLE;
    assign bus.done      = r_state == S_DONE;
    assign bus.div_error = r_div_error;
    assign bus.result_lo = r_res_lo;
    assign bus.result_hi = r_res_hi;
    assign bus.flags     = r_flags;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed vector table plus hand sequences for abort-by-reset and start-while-busy on alu_muldiv.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic        wide;
        logic [15:0] ta;
        logic [15:0] ta_hi;
        logic [15:0] tb;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        cyv;
        logic        err;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_muldiv_if #(.DATA_W(16)) bus ();
    alu_muldiv #(.DATA_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    vec_t v[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input int lat);
        return (op[1] || !FAST) ? lat : 2;
    endfunction

    // Starts an op at the current negedge and returns with time at the negedge of the done cycle.
    // inj_cyc > 0 drives a second start in that cycle, which must be ignored.
    task automatic run_op(input logic [1:0] op, input logic wide, input logic [15:0] ta,
                          input logic [15:0] ta_hi, input logic [15:0] tb, input flags_t fin,
                          input int inj_cyc, output int lat, output logic busy_ok);
        bus.operation = op;
        bus.wide      = wide;
        bus.ta        = ta;
        bus.ta_hi     = ta_hi;
        bus.tb        = tb;
        bus.flags_in  = fin;
        bus.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat       = -1;
        busy_ok   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == inj_cyc) begin
                bus.start     = 1'b1;
                bus.operation = 2'd0;
                bus.wide      = 1'b1;
                bus.ta        = 16'hFFFF;
                bus.tb        = 16'hFFFF;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat;
        int          ndone;
        logic        bok;
        flags_t      fin;
        flags_t      exp_fl;
        flags_t      prev_fl;
        logic [15:0] exp_lo, exp_hi, prev_lo, prev_hi;

        //        op    wide  ta        ta_hi     tb        lo        hi        cyv   err   lat
        v[0]  = '{2'd0, 1'b1, 16'h1234, 16'h0000, 16'h0100, 16'h3400, 16'h0012, 1'b1, 1'b0, 19};
        v[1]  = '{2'd1, 1'b0, 16'h00FE, 16'h0000, 16'h0003, 16'h00FA, 16'h00FF, 1'b0, 1'b0, 11};
        v[2]  = '{2'd2, 1'b1, 16'h0000, 16'h0001, 16'h0010, 16'h1000, 16'h0000, 1'b0, 1'b0, 19};
        v[3]  = '{2'd2, 1'b1, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 2};
        v[4]  = '{2'd2, 1'b1, 16'h0000, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1, 2};
        v[5]  = '{2'd3, 1'b0, 16'h00F9, 16'h00FF, 16'h0002, 16'h00FD, 16'h00FF, 1'b0, 1'b0, 11};
        v[6]  = '{2'd3, 1'b1, 16'h0000, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1, 19};
        v[7]  = '{2'd1, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 19};
        v[8]  = '{2'd1, 1'b1, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h4000, 1'b1, 1'b0, 19};
        v[9]  = '{2'd0, 1'b0, 16'h12FF, 16'h0000, 16'hAB02, 16'h00FE, 16'h0001, 1'b1, 1'b0, 11};
        v[10] = '{2'd3, 1'b1, 16'hFFF9, 16'hFFFF, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 19};
        v[11] = '{2'd3, 1'b0, 16'h0080, 16'h00FF, 16'h0001, 16'h0080, 16'h0000, 1'b0, 1'b0, 11};
        v[12] = '{2'd3, 1'b0, 16'h0080, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1, 11};
        v[13] = '{2'd2, 1'b0, 16'h00FF, 16'h007F, 16'h0080, 16'h00FF, 16'h007F, 1'b0, 1'b0, 11};
        v[14] = '{2'd0, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 19};
        v[15] = '{2'd3, 1'b1, 16'h0064, 16'h0000, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 19};

        bus.start     = 1'b0;
        bus.operation = 2'd0;
        bus.wide      = 1'b0;
        bus.ta        = '0;
        bus.ta_hi     = '0;
        bus.tb        = '0;
        bus.flags_in  = '0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_div_error", bus.div_error, 0);
        chk("rst_result_lo", bus.result_lo, 0);
        chk("rst_result_hi", bus.result_hi, 0);
        chk("rst_flags", bus.flags, 0);
        reset = 1'b0;
        @(negedge clk);

        prev_lo = '0;
        prev_hi = '0;
        prev_fl = '0;
        for (int i = 0; i < 16; i++) begin
            fin = flags_t'(6'((i * 13 + 7) % 64));
            run_op(v[i].op, v[i].wide, v[i].ta, v[i].ta_hi, v[i].tb, fin, 0, lat, bok);
            if (v[i].err) begin
                exp_lo = prev_lo;
                exp_hi = prev_hi;
                exp_fl = prev_fl;
            end else begin
                exp_lo = v[i].lo;
                exp_hi = v[i].hi;
                exp_fl = fin;
                if (!v[i].op[1]) begin
                    exp_fl.cy = v[i].cyv;
                    exp_fl.v  = v[i].cyv;
                end
            end
            chk($sformatf("v%0d_latency", i), lat, exp_lat(v[i].op, v[i].lat));
            chk($sformatf("v%0d_busy", i), bok, 1);
            chk($sformatf("v%0d_div_error", i), bus.div_error, v[i].err);
            chk($sformatf("v%0d_result_lo", i), bus.result_lo, exp_lo);
            chk($sformatf("v%0d_result_hi", i), bus.result_hi, exp_hi);
            chk($sformatf("v%0d_flags", i), bus.flags, exp_fl);
            prev_lo = exp_lo;
            prev_hi = exp_hi;
            prev_fl = exp_fl;
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
        end

        // Abort a wide MULU with reset in cycle 5
        bus.operation = 2'd0;
        bus.wide      = 1'b1;
        bus.ta        = 16'h1234;
        bus.tb        = 16'h0100;
        bus.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result_lo", bus.result_lo, 0);
        chk("abort_result_hi", bus.result_hi, 0);
        chk("abort_flags", bus.flags, 0);
        reset = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // Fresh op with a start injected while busy
        run_op(2'd2, 1'b1, 16'h0000, 16'h0001, 16'h0010, '0, 3, lat, bok);
        chk("restart_latency", lat, 19);
        chk("restart_busy", bok, 1);
        chk("restart_result_lo", bus.result_lo, 16'h1000);
        chk("restart_result_hi", bus.result_hi, 16'h0000);
        @(negedge clk);
        chk("ignored_start_idle", bus.busy, 0);

        // Start asserted in the done cycle is ignored
        run_op(2'd2, 1'b1, 16'h0064, 16'h0000, 16'h0007, '0, 19, lat, bok);
        chk("donecyc_latency", lat, 19);
        chk("donecyc_result_lo", bus.result_lo, 16'h000E);
        chk("donecyc_result_hi", bus.result_hi, 16'h0002);
        @(negedge clk);
        chk("donecyc_start_ignored", bus.busy, 0);
        bus.start = 1'b0;

        // Earliest accepted restart, byte MUL
        run_op(2'd1, 1'b0, 16'h00FE, 16'h0000, 16'h0003, '0, 0, lat, bok);
        chk("early_restart_latency", lat, exp_lat(2'd1, 11));
        chk("early_restart_result_lo", bus.result_lo, 16'h00FA);
        chk("early_restart_result_hi", bus.result_hi, 16'h00FF);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Sequential multiply/divide unit for the NEC core execution stage, sitting beside the single-cycle `alu`. It executes MULU, MUL, DIVU and DIV in byte or word mode, width-parametrised, using a radix-2 shift/add–subtract datapath. A start/busy/done handshake lets the sequencer stall. Divide-by-zero and quotient overflow are reported on `div_error` so the core can raise the divide exception.

## Interface
- `DATA_W`, 16: full operand width. Must be even and ≥8. Byte mode uses `DATA_W/2`.
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin operation; sampled only while idle
- `operation`  in  2  0=MULU, 1=MUL, 2=DIVU, 3=DIV
- `wide`  in  1  1 = n=`DATA_W`, 0 = n=`DATA_W/2`
- `ta`  in  DATA_W  multiplicand / dividend low half
- `ta_hi`  in  DATA_W  dividend high half (ignored for multiply)
- `tb`  in  DATA_W  multiplier / divisor
- `flags_in`  in  flags_t  current flags
- `result_lo`  out  DATA_W  product low / quotient
- `result_hi`  out  DATA_W  product high / remainder
- `flags`  out  flags_t  updated flags
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse
- `div_error`  out  1  valid with `done`; divide exception

## Operation
- Only the low n bits of `ta`, `ta_hi` and `tb` are used. Results occupy bits [n-1:0] of `result_lo`/`result_hi`; the upper bits are zero.
- Operands, `operation`, `wide` and `flags_in` are latched on the edge that samples `start`. A `start` while busy is ignored.
- States:
  - IDLE: waits for `start`, then goes to CHECK.
  - CHECK: takes operand magnitudes for signed ops and runs the divide pre-checks. Goes to RUN, or to DONE with error.
  - RUN: exactly n iterations, one bit per cycle, then goes to FIX.
  - FIX: applies signs and the signed overflow check, then goes to DONE.
  - DONE: pulses `done` and returns to IDLE.
- Multiply:
  - Product = {`result_hi`,`result_lo`}, 2n bits.
  - MULU: CY=V=1 iff the high half is nonzero.
  - MUL: CY=V=1 iff the high half is not the sign extension of the low half.
  - All other flags pass through from `flags_in`.
- Divide:
  - Dividend = {`ta_hi`,`ta`}, 2n bits. Quotient goes to `result_lo`, remainder to `result_hi`.
  - DIV truncates toward zero. The remainder takes the dividend's sign.
  - All flags pass through unchanged.
- Divide errors:
  - CHECK: divisor = 0. Also, for DIVU, dividend high half ≥ divisor.
  - FIX: for DIV, quotient outside [-2^(n-1), 2^(n-1)-1].
  - On error, `div_error`=1 with `done`, and `result_lo`/`result_hi`/`flags` hold their previous values.
- Outputs hold their last value until the next completion.

## Timing
- The cycle in which `start` is sampled is cycle 0.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Normal completion: `done` is high in cycle n+3. That is cycle 11 for byte mode and cycle 19 for word mode at `DATA_W`=16.
- A CHECK-detected error asserts `done` in cycle 2.
- `start` may be asserted in the `done` cycle. It is ignored, because busy is still high. The earliest accepted restart is the cycle after `done`.
- Reset values: `busy`=0, `done`=0, `div_error`=0, `result_lo`=0, `result_hi`=0, `flags`=0; state is IDLE.
- Reset asserted mid-operation aborts it. No `done` is produced, and all outputs take their reset values on the next edge.

## Configuration
- `ALU_MULDIV_FAST_MUL_EN`
  - Defined: MULU/MUL use a single-cycle combinational multiplier. CHECK goes directly to DONE, so `done` is in cycle 2 for both widths. Flag and result behaviour is identical.
  - Undefined: the iterative multiply is used, with the n+3 latency.
  - Divide is unaffected either way.

## Test plan
- MULU, wide, `ta`=0x1234, `tb`=0x0100 -> `result_hi`=0x0012, `result_lo`=0x3400, CY=V=1, `done` in cycle 19 (cycle 2 with the macro defined).
- MUL, byte, `ta`=0xFE, `tb`=0x03 -> `result_hi`=0x00FF, `result_lo`=0x00FA, CY=V=0, `done` in cycle 11.
- DIVU, wide, {`ta_hi`,`ta`}=0x0001_0000, `tb`=0x0010 -> `result_lo`=0x1000, `result_hi`=0, `div_error`=0.
- DIVU, wide, `tb`=0 -> `div_error`=1 and `done` in cycle 2, results unchanged. Separately, DIVU with `ta_hi`=0x0010 and `tb`=0x0010 -> same error in cycle 2.
- DIV, byte, {0xFF,0xF9} (-7) / 0x02 -> `result_lo`=0x00FD, `result_hi`=0x00FF. DIV, wide, 0x8000_0000 / 0x0001 -> `div_error`=1 in cycle 19.
- Combined control case:
  - Start a wide MULU and assert `reset` in cycle 5. Expect `busy`=0, no `done`, outputs zero.
  - Then start a new op. Expect `done` 19 cycles after its start.
  - Assert `start` while busy. Expect it to be ignored.
